// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder_tree front end.
// Contents:
//   BITWIDTH, NUMBER_OF_ADDENDS : default addend width and frame size
//   FRAME_COUNT_W               : width of the delivered-frame counter
//   collector_state_t           : collector FSM states (FILL, WAIT)
package adder_tree_pkg;

  localparam int BITWIDTH          = 8;
  localparam int NUMBER_OF_ADDENDS = 9;
  localparam int FRAME_COUNT_W     = 16;

  typedef enum logic {
    FILL = 1'b0,  // staging accepts beats
    WAIT = 1'b1   // a closed frame sits in staging until the output frees
  } collector_state_t;

endpackage

// File: rtl/addend_collector_if.sv
// Handshake bundle between a serial addend producer, the collector and the
// parallel consumer (adder_tree).
// Signals:
//   in_valid/in_ready/in_data/in_last : serial addend stream
//   values/out_valid/out_ready        : parallel frame stream
//   out_short                         : frame was closed early by in_last
// Modports:
//   slave  : the collector
//   master : producer + consumer side (bench or surrounding logic)
interface addend_collector_if
  import adder_tree_pkg::*;
#(
  parameter int bitwidth        = BITWIDTH,
  parameter int numberOfAddends = NUMBER_OF_ADDENDS
) ();

  logic                                          in_valid;
  logic                                          in_ready;
  logic [bitwidth-1:0]                           in_data;
  logic                                          in_last;
  logic [0:numberOfAddends-1][bitwidth-1:0]      values;
  logic                                          out_valid;
  logic                                          out_ready;
  logic                                          out_short;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, values, out_valid, out_short
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, values, out_valid, out_short
  );

endinterface

// File: rtl/addend_collector.sv
// Serial-to-parallel addend collector feeding adder_tree.
// Beats are written into a staging buffer slot by slot; when a frame closes
// (last slot or in_last) it moves into the output register if that register
// is free, otherwise the collector stalls in WAIT until the consumer takes the
// pending output.
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous, active-high reset
//   bus         : addend_collector_if.slave (input stream + parallel output)
//   frame_count : frames delivered (out_valid && out_ready), wraps at 2^16
module addend_collector
  import adder_tree_pkg::*;
#(
  parameter int bitwidth        = BITWIDTH,
  parameter int numberOfAddends = NUMBER_OF_ADDENDS
) (
  input  logic                     clock,
  input  logic                     reset,
  addend_collector_if.slave        bus,
  output logic [FRAME_COUNT_W-1:0] frame_count
);

  localparam int IDX_W = $clog2(numberOfAddends);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numberOfAddends - 1);

  typedef logic [0:numberOfAddends-1][bitwidth-1:0] frame_t;

  collector_state_t         state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  frame_t                   staging_reg, staging_next;
  logic                     short_pending_reg, short_pending_next;
  frame_t                   values_reg, values_next;
  logic                     out_valid_reg, out_valid_next;
  logic                     out_short_reg, out_short_next;
  logic [FRAME_COUNT_W-1:0] frame_count_reg, frame_count_next;

  logic   in_ready_int;
  logic   accept, at_last, close, early, out_free, handshake;
  logic   load, load_short;
  frame_t staged_frame;  // staging with the current beat already written in

  // Ready is a decode of the state register only; gating with reset keeps it
  // low while reset is held and lets it rise as soon as reset is released.
  assign in_ready_int = !reset && (state_reg == FILL);

  assign accept    = bus.in_valid && in_ready_int;
  assign at_last   = (idx_reg == LAST_IDX);
  assign close     = accept && (at_last || bus.in_last);
  assign early     = accept && bus.in_last && !at_last;
  assign out_free  = !out_valid_reg || bus.out_ready;
  assign handshake = out_valid_reg && bus.out_ready;

  // The closing beat must reach the output on the same edge it is accepted,
  // so the output register loads from this merged view rather than staging.
  for (genvar gi = 0; gi < numberOfAddends; gi++) begin : g_slot
    assign staged_frame[gi] = (accept && (idx_reg == IDX_W'(gi))) ? bus.in_data
                                                                  : staging_reg[gi];
  end

  always_comb begin
    state_next         = state_reg;
    idx_next           = idx_reg;
    short_pending_next = short_pending_reg;
    values_next        = values_reg;
    out_valid_next     = out_valid_reg;
    out_short_next     = out_short_reg;
    frame_count_next   = frame_count_reg;
    load               = 1'b0;
    load_short         = 1'b0;

    case (state_reg)
      FILL: begin
        if (close) begin
          if (out_free) begin
            load       = 1'b1;
            load_short = early;
          end else begin
            state_next         = WAIT;
            short_pending_next = early;
          end
        end
      end
      WAIT: begin
        if (bus.out_ready) begin
          load               = 1'b1;
          load_short         = short_pending_reg;
          state_next         = FILL;
          short_pending_next = 1'b0;
        end
      end
      default: state_next = FILL;
    endcase

    if (close) begin
      idx_next = '0;
    end else if (accept) begin
      idx_next = idx_reg + IDX_W'(1);
    end

    // Clearing staging on every transfer is what zero-fills short frames.
    staging_next = load ? '0 : staged_frame;

    if (load) begin
      values_next    = staged_frame;
      out_short_next = load_short;
      out_valid_next = 1'b1;
    end else if (handshake) begin
      out_valid_next = 1'b0;
    end

    if (handshake) begin
      frame_count_next = frame_count_reg + FRAME_COUNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= FILL;
      idx_reg           <= '0;
      staging_reg       <= '0;
      short_pending_reg <= 1'b0;
      values_reg        <= '0;
      out_valid_reg     <= 1'b0;
      out_short_reg     <= 1'b0;
      frame_count_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      idx_reg           <= idx_next;
      staging_reg       <= staging_next;
      short_pending_reg <= short_pending_next;
      values_reg        <= values_next;
      out_valid_reg     <= out_valid_next;
      out_short_reg     <= out_short_next;
      frame_count_reg   <= frame_count_next;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.values    = values_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_short = out_short_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_addend_collector.sv
// Self-checking bench for addend_collector: scenario tasks push expected
// frames into a queue, a monitor records every delivered frame, and each
// task compares the two streams inline.
module tb_addend_collector;
  import adder_tree_pkg::*;

  localparam int BW = 8;
  localparam int N  = 9;

  typedef logic [0:N-1][BW-1:0] frame_t;
  typedef struct packed {
    frame_t v;
    logic   s;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] frame_count;

  addend_collector_if #(.bitwidth(BW), .numberOfAddends(N)) bus ();

  addend_collector #(.bitwidth(BW), .numberOfAddends(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  int   checks   = 0;
  int   failures = 0;
  int   stalls   = 0;
  int   got_rd   = 0;
  rec_t exp_q[$];
  rec_t got_q[$];

  // Record each frame at the negedge preceding its handshake edge.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.values, bus.out_short});
  end

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input logic l);
    int n;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clock);
    while (!bus.in_ready && n < 100) begin
      n++;
      stalls++;
      @(negedge clock);
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout in_ready=%0b required=1 within 100 cycles", bus.in_ready);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Sends the first len slots of f; in_last marks the final beat only when
  // the frame is short.  The expected delivered frame is zero-filled.
  task automatic send_frame(input frame_t f, input int len, input bit push);
    rec_t r;
    r.v = '0;
    r.s = (len < N);
    for (int i = 0; i < len; i++) r.v[i] = f[i];
    if (push) exp_q.push_back(r);
    for (int i = 0; i < len; i++) send_beat(f[i], (i == len - 1) && (len < N));
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_ready_held got=%0b exp=0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_short !== 1'b0) begin
      failures++;
      $display("FAIL rst_out_flags got=%0b%0b exp=00", bus.out_valid, bus.out_short);
    end
    checks++;
    if (bus.values !== '0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_values_count got=%h/%0d exp=0/0", bus.values, frame_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready_release got=%0b exp=1", bus.in_ready);
    end
    got_rd = got_q.size();
  endtask

  task automatic test_full_frame();
    frame_t f;
    rec_t   e, g;
    do_reset();
    f = {8'd9, 8'd16, 8'd21, 8'd24, 8'd25, 8'd24, 8'd21, 8'd16, 8'd9};
    bus.out_ready = 1'b1;
    send_frame(f, 9, 1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.values !== f || bus.out_short !== 1'b0) begin
      failures++;
      $display("FAIL full_out got=%0b/%h/%0b exp=1/%h/0", bus.out_valid, bus.values, bus.out_short, f);
    end
    @(posedge clock);
    #1;
    checks++;
    if (frame_count !== 16'd1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_count got=%0d/%0b exp=1/0", frame_count, bus.out_valid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_rd >= got_q.size()) begin
        failures++;
        $display("FAIL full_sb_missing got=none exp=%h", e);
      end else begin
        g = got_q[got_rd];
        got_rd++;
        if (g !== e) begin
          failures++;
          $display("FAIL full_sb got=%h exp=%h", g, e);
        end
      end
    end
    $display("full_frame: frame_count=%0d", frame_count);
  endtask

  task automatic test_short_frame();
    frame_t s, f, es;
    rec_t   e, g;
    do_reset();
    s  = {8'd1, 8'd2, 8'd3, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77};
    es = {8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    f  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    bus.out_ready = 1'b1;
    send_frame(s, 3, 1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.values !== es || bus.out_short !== 1'b1) begin
      failures++;
      $display("FAIL short_out got=%0b/%h/%0b exp=1/%h/1", bus.out_valid, bus.values, bus.out_short, es);
    end
    send_frame(f, 9, 1);
    checks++;
    if (bus.values !== f || bus.out_short !== 1'b0) begin
      failures++;
      $display("FAIL short_next got=%h/%0b exp=%h/0", bus.values, bus.out_short, f);
    end
    @(posedge clock);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_rd >= got_q.size()) begin
        failures++;
        $display("FAIL short_sb_missing got=none exp=%h", e);
      end else begin
        g = got_q[got_rd];
        got_rd++;
        if (g !== e) begin
          failures++;
          $display("FAIL short_sb got=%h exp=%h", g, e);
        end
      end
    end
    $display("short_frame: frame_count=%0d", frame_count);
  endtask

  task automatic test_back_pressure();
    frame_t a, b;
    rec_t   e, g;
    do_reset();
    a = {8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19};
    b = {8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29};
    bus.out_ready = 1'b0;
    send_frame(a, 9, 1);
    send_frame(b, 9, 1);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.values !== a) begin
      failures++;
      $display("FAIL bp_held got=%0b/%0b/%h exp=0/1/%h", bus.in_ready, bus.out_valid, bus.values, a);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.values !== a || bus.out_short !== 1'b0) begin
      failures++;
      $display("FAIL bp_stable got=%0b/%h/%0b exp=0/%h/0", bus.in_ready, bus.values, bus.out_short, a);
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.values !== b || bus.in_ready !== 1'b1 || frame_count !== 16'd1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got=%h/%0b/%0d/%0b exp=%h/1/1/1", bus.values, bus.in_ready, frame_count, bus.out_valid, b);
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (frame_count !== 16'd2 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got=%0d/%0b exp=2/0", frame_count, bus.out_valid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_rd >= got_q.size()) begin
        failures++;
        $display("FAIL bp_sb_missing got=none exp=%h", e);
      end else begin
        g = got_q[got_rd];
        got_rd++;
        if (g !== e) begin
          failures++;
          $display("FAIL bp_sb got=%h exp=%h", g, e);
        end
      end
    end
    $display("back_pressure: frame_count=%0d", frame_count);
  endtask

  task automatic test_back_to_back();
    frame_t f;
    rec_t   e, g;
    do_reset();
    bus.out_ready = 1'b1;
    stalls = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) f[i] = 8'(16 * k + i + 40);
      send_frame(f, 9, 1);
    end
    // Single-beat frames: every close coincides with an output handshake.
    for (int k = 0; k < 4; k++) begin
      f    = '0;
      f[0] = 8'(200 + k);
      send_frame(f, 1, 1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.values[0] !== f[0]) begin
        failures++;
        $display("FAIL b2b_simul k=%0d got=%0b/%0d exp=1/%0d", k, bus.out_valid, bus.values[0], f[0]);
      end
    end
    checks++;
    if (stalls !== 0) begin
      failures++;
      $display("FAIL b2b_bubbles got=%0d exp=0", stalls);
    end
    @(posedge clock);
    #1;
    checks++;
    if (frame_count !== 16'd6) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=6", frame_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_rd >= got_q.size()) begin
        failures++;
        $display("FAIL b2b_sb_missing got=none exp=%h", e);
      end else begin
        g = got_q[got_rd];
        got_rd++;
        if (g !== e) begin
          failures++;
          $display("FAIL b2b_sb got=%h exp=%h", g, e);
        end
      end
    end
    checks++;
    if (got_rd != got_q.size()) begin
      failures++;
      $display("FAIL b2b_sb_extra got=%0d exp=%0d", got_q.size(), got_rd);
    end
    $display("back_to_back: frame_count=%0d stalls=%0d", frame_count, stalls);
  endtask

  task automatic test_reset_mid_frame();
    frame_t a, f;
    rec_t   e, g;
    do_reset();
    a = {8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'd39};
    f = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    bus.out_ready = 1'b1;
    send_frame(a, 1, 0);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    send_frame(a, 9, 0);
    for (int i = 0; i < 4; i++) send_beat(8'(90 + i), 1'b0);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_short !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_flags got=%0b/%0b/%0b exp=0/0/0", bus.out_valid, bus.out_short, bus.in_ready);
    end
    checks++;
    if (bus.values !== '0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL midrst_clear got=%h/%0d exp=0/0", bus.values, frame_count);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    got_rd = got_q.size();
    bus.out_ready = 1'b1;
    send_frame(f, 9, 1);
    checks++;
    if (bus.values !== f || bus.out_short !== 1'b0) begin
      failures++;
      $display("FAIL midrst_next got=%h/%0b exp=%h/0", bus.values, bus.out_short, f);
    end
    @(posedge clock);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_rd >= got_q.size()) begin
        failures++;
        $display("FAIL midrst_sb_missing got=none exp=%h", e);
      end else begin
        g = got_q[got_rd];
        got_rd++;
        if (g !== e) begin
          failures++;
          $display("FAIL midrst_sb got=%h exp=%h", g, e);
        end
      end
    end
    $display("reset_mid_frame: frame_count=%0d", frame_count);
  endtask

  task automatic test_counter_wrap();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) send_beat(8'(i), 1'b1);
    checks++;
    if (frame_count !== 16'hFFFF || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pre got=%h/%0b exp=ffff/1", frame_count, bus.out_valid);
    end
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (frame_count !== 16'd0) begin
      failures++;
      $display("FAIL wrap_zero got=%h exp=0000", frame_count);
    end
    got_rd = got_q.size();
    $display("counter_wrap: frame_count=%0d", frame_count);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
